bmsce_tdm_demux: RTL and testbench

Time-division 1:2 demultiplexer for the two-channel serial stream produced by our 2:1 mux designs. Each valid beat carries one bit from either channel A or channel B. The block steers each bit to its channel's nibble shift register and presents completed 4-bit words on the dedicated outputs. Slot order comes from an internal frame sequencer (auto mode) or from an explicit select pin (manual mode, the inverse of the mux `sel`).

---
 rtl/bmsce_tdm_demux_if.sv | 28 ++
 rtl/bmsce_tdm_demux.sv | 149 ++++++++++++++
 tb/tb_bmsce_tdm_demux.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmsce_tdm_demux_if.sv
// Pad-level bus of the TDM demultiplexer: dedicated inputs/outputs plus the
// bidirectional pad group. The block drives outputs through the slave modport.
interface bmsce_tdm_demux_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/bmsce_tdm_demux.sv
// Two-channel time-division demultiplexer. Each accepted beat carries one bit
// for channel A or B; bits are gathered MSB-first into 4-bit words per
// channel. Slot order comes from an internal sequencer (auto mode, locked by a
// sync beat) or from an explicit select pin (manual mode).
module bmsce_tdm_demux (
  input  logic                  clk,
  input  logic                  rst_n,
  bmsce_tdm_demux_if.slave      bus
);

  // Decoded input fields
  logic din;
  logic sync;
  logic valid;
  logic manual;
  logic msel;
  logic err_clr;

  assign din     = bus.ui_in[0];
  assign sync    = bus.ui_in[1];
  assign valid   = bus.ui_in[2];
  assign manual  = bus.ui_in[3];
  assign msel    = bus.ui_in[4];
  assign err_clr = bus.ui_in[5];

  // Inputs that carry no function in this block
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:6]};

  // Sequencer state
  logic slot_q,     slot_d;
  logic locked_q,   locked_d;
  logic sync_err_q, sync_err_d;

  // Per-channel views exported from the channel generate blocks
  logic [3:0] word_w [2];
  logic [1:0] idx_w  [2];
  logic       upd_w  [2];

  // Beat qualification. In auto mode nothing is accepted until the stream has
  // shown a sync beat; a sync beat is itself always accepted so it can lock.
  logic accept;
  logic tgt;            // 0 = channel A, 1 = channel B
  logic sync_hit;       // accepted beat that restarts the frame
  logic frame_partial;  // some channel is midway through a word

  assign accept        = valid & (manual | locked_q | sync);
  assign tgt           = manual ? msel : (sync ? 1'b0 : slot_q);
  assign sync_hit      = accept & sync;
  assign frame_partial = (idx_w[0] != 2'd0) | (idx_w[1] != 2'd0);

  // Next-state for slot sequencer, lock flag and sticky sync error
  always_comb begin
    slot_d     = slot_q;
    locked_d   = locked_q;
    sync_err_d = sync_err_q;
    if (accept && !manual) begin
      slot_d = ~tgt;
    end
    if (sync_hit && !manual) begin
      locked_d = 1'b1;
    end
    // A sync arriving while a word is still partial means the framing slipped;
    // setting wins over a simultaneous clear.
    if (sync_hit && locked_q && frame_partial) begin
      sync_err_d = 1'b1;
    end else if (err_clr) begin
      sync_err_d = 1'b0;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  // One identical shift/assemble slice per channel; gi = 0 is A, gi = 1 is B
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH_ID = 1'(gi);

      logic       hit;
      logic [3:0] sh_q,   sh_d;
      logic [1:0] idx_q,  idx_d;
      logic [3:0] word_q, word_d;
      logic       upd_q,  upd_d;
      logic [3:0] base_sh;
      logic [1:0] base_idx;
      logic [3:0] shifted;

      assign hit = accept & (tgt == CH_ID);

      // Shift in the beat bit; a sync beat first discards any partial word so
      // its own bit lands as index 0. The fourth bit publishes the word.
      always_comb begin
        base_sh  = sync_hit ? 4'd0 : sh_q;
        base_idx = sync_hit ? 2'd0 : idx_q;
        shifted  = {base_sh[2:0], din};
        sh_d     = base_sh;
        idx_d    = base_idx;
        word_d   = word_q;
        upd_d    = 1'b0;
        if (hit) begin
          idx_d = base_idx + 2'd1;
          if (base_idx == 2'd3) begin
            word_d = shifted;
            upd_d  = 1'b1;
            sh_d   = 4'd0;
          end else begin
            sh_d = shifted;
          end
        end
      end

      // Channel registers; the update strobe lives for exactly one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q   <= 4'd0;
          idx_q  <= 2'd0;
          word_q <= 4'd0;
          upd_q  <= 1'b0;
        end else begin
          sh_q   <= sh_d;
          idx_q  <= idx_d;
          word_q <= word_d;
          upd_q  <= upd_d;
        end
      end

      assign word_w[gi] = word_q;
      assign idx_w[gi]  = idx_q;
      assign upd_w[gi]  = upd_q;
    end
  endgenerate

  // All outputs come straight from registers
  assign bus.uo_out  = {word_w[1], word_w[0]};
  assign bus.uio_out = {3'b000, locked_q, slot_q, sync_err_q, upd_w[1], upd_w[0]};
  assign bus.uio_oe  = 8'h1F;

endmodule

// File: tb/tb_bmsce_tdm_demux.sv
// Bench for the TDM demultiplexer: directed scenarios plus a random stream,
// every cycle compared against a queue-based behavioural model.
module tb_bmsce_tdm_demux;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bmsce_tdm_demux_if bus ();

  bmsce_tdm_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: bits collected per channel in queues
  bit       m_locked;
  bit       m_slot;
  bit       m_err;
  bit       m_upd_a;
  bit       m_upd_b;
  bit [3:0] m_word_a;
  bit [3:0] m_word_b;
  bit       m_qa[$];
  bit       m_qb[$];

  task automatic m_reset();
    m_locked = 0; m_slot = 0; m_err = 0; m_upd_a = 0; m_upd_b = 0;
    m_word_a = 0; m_word_b = 0;
    m_qa.delete(); m_qb.delete();
  endtask

  task automatic m_step(input bit v, input bit d, input bit s, input bit man,
                        input bit ms, input bit ec);
    bit tgt;
    bit set_err;
    set_err = 0;
    m_upd_a = 0;
    m_upd_b = 0;
    if (v && (man || m_locked || s)) begin
      tgt = man ? ms : (s ? 1'b0 : m_slot);
      if (s) begin
        if (m_locked && (m_qa.size() != 0 || m_qb.size() != 0)) set_err = 1;
        m_qa.delete();
        m_qb.delete();
        if (!man) m_locked = 1;
      end
      if (!tgt) begin
        m_qa.push_back(d);
        if (m_qa.size() == 4) begin
          m_word_a = {m_qa[0], m_qa[1], m_qa[2], m_qa[3]};
          m_upd_a = 1;
          m_qa.delete();
        end
      end else begin
        m_qb.push_back(d);
        if (m_qb.size() == 4) begin
          m_word_b = {m_qb[0], m_qb[1], m_qb[2], m_qb[3]};
          m_upd_b = 1;
          m_qb.delete();
        end
      end
      if (!man) m_slot = !tgt;
    end
    if (set_err) m_err = 1;
    else if (ec) m_err = 0;
  endtask

  function automatic logic [7:0] exp_uo();
    return {m_word_b, m_word_a};
  endfunction

  function automatic logic [7:0] exp_uio();
    return {3'b000, m_locked, m_slot, m_err, m_upd_b, m_upd_a};
  endfunction

  // Drive one clock's inputs on the falling edge, let the model see the edge
  task automatic cyc(input bit v, input bit d, input bit s, input bit man,
                     input bit ms, input bit ec);
    @(negedge clk);
    bus.ui_in = {2'b00, ec, ms, man, v, s, d};
    @(posedge clk);
    m_step(v, d, s, man, ms, ec);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ui_in = 8'h00;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in = 8'h00;
    m_reset();
    #2;
    total++;
    if (bus.uo_out !== 8'h00) begin
      bad++; $display("FAIL reset_uo_out got=%h want=00", bus.uo_out);
    end
    total++;
    if (bus.uio_out !== 8'h00) begin
      bad++; $display("FAIL reset_uio_out got=%h want=00", bus.uio_out);
    end
    total++;
    if (bus.uio_oe !== 8'h1F) begin
      bad++; $display("FAIL reset_uio_oe got=%h want=1f", bus.uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    bit [7:0] bits;
    bits = 8'b10011100;  // din sequence 1,0,0,1,1,1,0,0 (first beat is MSB)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, bits[7-i], i == 0, 0, 0, 0);
      total++;
      if (bus.uo_out !== exp_uo()) begin
        bad++; $display("FAIL frame_uo beat=%0d got=%h want=%h", i, bus.uo_out, exp_uo());
      end
      total++;
      if (bus.uio_out !== exp_uio()) begin
        bad++; $display("FAIL frame_uio beat=%0d got=%h want=%h", i, bus.uio_out, exp_uio());
      end
      if (i == 6) begin
        total++;
        if (bus.uo_out[3:0] !== 4'hA || bus.uio_out[1:0] !== 2'b01) begin
          bad++; $display("FAIL frame_wordA got=%h upd=%b want=a upd=01", bus.uo_out[3:0], bus.uio_out[1:0]);
        end
      end
    end
    total++;
    if (bus.uo_out !== 8'h6A || bus.uio_out[1:0] !== 2'b10) begin
      bad++; $display("FAIL frame_final got=%h upd=%b want=6a upd=10", bus.uo_out, bus.uio_out[1:0]);
    end
    total++;
    if (bus.uio_out[4] !== 1'b1 || bus.uio_out[2] !== 1'b0) begin
      bad++; $display("FAIL frame_lock_err got=%b/%b want=1/0", bus.uio_out[4], bus.uio_out[2]);
    end
  endtask

  task automatic test_unlocked();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1'($urandom), 0, 0, 0, 0);
      total++;
      if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
        bad++; $display("FAIL unlocked beat=%0d got=%h/%h want=00/00", i, bus.uo_out, bus.uio_out);
      end
    end
  endtask

  task automatic test_sync_err();
    // continues from a locked state holding 8'h6A
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, i == 0, 0, 0, 0);
    end
    cyc(1, 1, 1, 0, 0, 0);
    total++;
    if (bus.uio_out[2] !== 1'b1 || bus.uo_out !== 8'h6A) begin
      bad++; $display("FAIL sync_err_set got=%b/%h want=1/6a", bus.uio_out[2], bus.uo_out);
    end
    for (int i = 1; i < 8; i++) begin
      cyc(1, (i % 2) == 0, 0, 0, 0, 0);
      total++;
      if (bus.uio_out !== exp_uio() || bus.uo_out !== exp_uo()) begin
        bad++; $display("FAIL sync_err_frame beat=%0d got=%h/%h want=%h/%h", i, bus.uo_out, bus.uio_out, exp_uo(), exp_uio());
      end
    end
    total++;
    if (bus.uo_out !== 8'h0F || bus.uio_out[2] !== 1'b1) begin
      bad++; $display("FAIL sync_err_word got=%h/%b want=0f/1", bus.uo_out, bus.uio_out[2]);
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (bus.uio_out[2] !== 1'b0) begin
      bad++; $display("FAIL sync_err_clear got=%b want=0", bus.uio_out[2]);
    end
  endtask

  task automatic test_gaps();
    bit [7:0] bits;
    int       pa;
    int       pb;
    bits = 8'b10011100;
    pa = 0;
    pb = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, bits[7-i], i == 0, 0, 0, 0);
      pa += int'(bus.uio_out[0]);
      pb += int'(bus.uio_out[1]);
      total++;
      if (bus.uio_out !== exp_uio() || bus.uo_out !== exp_uo()) begin
        bad++; $display("FAIL gaps_beat beat=%0d got=%h/%h want=%h/%h", i, bus.uo_out, bus.uio_out, exp_uo(), exp_uio());
      end
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        cyc(0, 1'($urandom), 1'($urandom), 0, 0, 0);
        pa += int'(bus.uio_out[0]);
        pb += int'(bus.uio_out[1]);
        total++;
        if (bus.uio_out !== exp_uio() || bus.uo_out !== exp_uo()) begin
          bad++; $display("FAIL gaps_idle beat=%0d got=%h/%h want=%h/%h", i, bus.uo_out, bus.uio_out, exp_uo(), exp_uio());
        end
      end
    end
    total++;
    if (bus.uo_out !== 8'h6A || pa != 1 || pb != 1) begin
      bad++; $display("FAIL gaps_result got=%h pulses=%0d/%0d want=6a pulses=1/1", bus.uo_out, pa, pb);
    end
  endtask

  task automatic test_manual();
    bit slot_before;
    bit [3:0] pat;
    slot_before = bus.uio_out[3];
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
    end
    total++;
    if (bus.uo_out !== 8'h6F || bus.uio_out[0] !== 1'b1 || bus.uio_out[3] !== slot_before) begin
      bad++; $display("FAIL manual_a got=%h/%h want=6f upd=1 slot=%b", bus.uo_out, bus.uio_out, slot_before);
    end
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc(1, pat[3-i], 0, 1, 1, 0);
      total++;
      if (bus.uio_out !== exp_uio() || bus.uo_out !== exp_uo()) begin
        bad++; $display("FAIL manual_b beat=%0d got=%h/%h want=%h/%h", i, bus.uo_out, bus.uio_out, exp_uo(), exp_uio());
      end
    end
    total++;
    if (bus.uo_out !== 8'h5F) begin
      bad++; $display("FAIL manual_b_word got=%h want=5f", bus.uo_out);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, i == 0, 0, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%h/%h want=00/00", bus.uo_out, bus.uio_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      total++;
      if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
        bad++; $display("FAIL post_reset_unlocked beat=%0d got=%h/%h want=00/00", i, bus.uo_out, bus.uio_out);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, i == 0, 0, 0, 0);
    end
    total++;
    if (bus.uo_out !== 8'hFF || bus.uio_out[4] !== 1'b1) begin
      bad++; $display("FAIL post_reset_frame got=%h locked=%b want=ff/1", bus.uo_out, bus.uio_out[4]);
    end
  endtask

  task automatic test_random();
    bit man;
    do_reset();
    man = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19, 0) == 0) man = !man;
      cyc($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(11, 0) == 0,
          man, 1'($urandom), $urandom_range(15, 0) == 0);
      total++;
      if (bus.uo_out !== exp_uo()) begin
        bad++; $display("FAIL random_uo cyc=%0d got=%h want=%h", i, bus.uo_out, exp_uo());
      end
      total++;
      if (bus.uio_out !== exp_uio()) begin
        bad++; $display("FAIL random_uio cyc=%0d got=%h want=%h", i, bus.uio_out, exp_uio());
      end
    end
    total++;
    if (bus.uio_oe !== 8'h1F) begin
      bad++; $display("FAIL random_uio_oe got=%h want=1f", bus.uio_oe);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_frame();
    test_unlocked();
    test_frame();
    test_sync_err();
    test_gaps();
    test_manual();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
